// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared definitions for the trace stream arbiter and related
//               round-robin blocks: checker framing characters, the arbiter
//               state encoding and default sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

  // Checker message framing characters
  localparam logic [7:0] CH_START = 8'h5E;  // '^'
  localparam logic [7:0] CH_END   = 8'h23;  // '#'

  // Default sizing
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_LEN   = 64;
  localparam int DEF_STALL_MAX = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/trace_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : trace_stream_arbiter_if
// Description : Bundle between NUM_REQ trace sources, the arbiter and the
//               cpu_checker character port.
//   req_valid [NUM_REQ]   source i presents a char
//   req_char  [8*NUM_REQ] char of source i in bits [8i+7:8i]
//   req_ready [NUM_REQ]   char of source i consumed this cycle
//   out_char  [8]         registered char to checker
//   out_valid             out_char valid this cycle
//   grant_id  [ID_W]      current owner index
//   busy                  grant held
//   abort                 one-cycle pulse on forced release
//   modport master : source/checker side, modport slave : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_stream_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_char;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           out_char;
  logic                 out_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 abort;

  modport master (
    output req_valid, req_char,
    input  req_ready, out_char, out_valid, grant_id, busy, abort
  );

  modport slave (
    input  req_valid, req_char,
    output req_ready, out_char, out_valid, grant_id, busy, abort
  );

endinterface
`default_nettype wire

// File: rtl/trace_stream_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector. Returns the first set
//               bit of req searching from rr_ptr upward with wrap-around.
//   req     [NUM_REQ] request vector
//   rr_ptr  [ID_W]    highest-priority index this cycle
//   winner  [ID_W]    selected index (rr_ptr when nothing requests)
//   any_req           at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [ID_W-1:0]    rr_ptr,
  output logic      [ID_W-1:0]    winner,
  output logic                    any_req
);

  int idx;

  // Walk offsets from farthest to nearest so the requester closest to
  // rr_ptr overwrites every other candidate.
  always_comb begin
    winner  = rr_ptr;
    any_req = |req;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[ID_W'(idx)]) begin
        winner = ID_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/trace_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : trace_stream_arbiter
// Description : Shares one cpu_checker character port between NUM_REQ trace
//               sources. Grants are message-granular (held until '#'),
//               round-robin between messages, with forced release after
//               MAX_LEN chars and, when TRACE_ARB_TIMEOUT_EN is defined,
//               after STALL_MAX consecutive stall cycles.
//   clk, reset  clock, synchronous active-high reset
//   bus         trace_stream_arbiter_if.slave (requests in, stream out)
// Build macro : TRACE_ARB_TIMEOUT_EN - enables the stall counter/release
// Revision    : 1.0 - initial release
// ============================================================================
module trace_stream_arbiter
  import trace_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ID_W      = 2,
  parameter int MAX_LEN   = DEF_MAX_LEN
`ifdef TRACE_ARB_TIMEOUT_EN
  ,
  parameter int STALL_MAX = DEF_STALL_MAX
`endif
) (
  input wire logic               clk,
  input wire logic               reset,
  trace_stream_arbiter_if.slave  bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]      char_q, char_d;
  logic            ov_q, ov_d;
  logic            abort_q, abort_d;
  logic [ID_W-1:0] winner;
  logic            any_req;
  logic            sel_valid;
  logic [7:0]      cur_char;
  logic            release_now;

`ifdef TRACE_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(STALL_MAX + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req     (bus.req_valid),
    .rr_ptr  (rr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Owner's valid/char selected with constant indices only
  always_comb begin
    sel_valid = 1'b0;
    cur_char  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid = bus.req_valid[i];
        cur_char  = bus.req_char[8*i +: 8];
      end
    end
  end

  // Ready is combinational from state and owner so the source sees the
  // consume strobe in the same cycle as its valid.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign bus.req_ready[i] = (state_q == HOLD) && (grant_q == ID_W'(i));
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    len_d       = len_q;
    char_d      = char_q;
    ov_d        = 1'b0;
    abort_d     = 1'b0;
    release_now = 1'b0;
`ifdef TRACE_ARB_TIMEOUT_EN
    stall_d     = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = HOLD;
          grant_d = winner;
          len_d   = '0;
`ifdef TRACE_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      HOLD: begin
        if (sel_valid) begin
          ov_d   = 1'b1;
          char_d = cur_char;
          len_d  = len_q + 1'b1;
`ifdef TRACE_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          // '#' takes precedence over the length limit: no abort then
          if (cur_char == CH_END) begin
            release_now = 1'b1;
          end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
            release_now = 1'b1;
            abort_d     = 1'b1;
          end
        end else begin
`ifdef TRACE_ARB_TIMEOUT_EN
          stall_d = stall_q + 1'b1;
          if (stall_q == STALL_W'(STALL_MAX - 1)) begin
            release_now = 1'b1;
            abort_d     = 1'b1;
          end
`endif
        end
        if (release_now) begin
          state_d = IDLE;
          // Releasing source drops to lowest priority
          rr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      len_q   <= '0;
      char_q  <= 8'h00;
      ov_q    <= 1'b0;
      abort_q <= 1'b0;
`ifdef TRACE_ARB_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      char_q  <= char_d;
      ov_q    <= ov_d;
      abort_q <= abort_d;
`ifdef TRACE_ARB_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign bus.out_char  = char_q;
  assign bus.out_valid = ov_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == HOLD);
  assign bus.abort     = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_stream_arbiter
// Description : Self-checking bench for trace_stream_arbiter. A cycle table
//               covers arbitration/ready timing; scoreboarded message streams
//               cover ordering, integrity, gaps and length abort; hand-written
//               sequences cover stall handling and mid-message reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_stream_arbiter;
  import trace_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int MAX_LEN   = 64;
  localparam int STALL_MAX = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trace_stream_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  trace_stream_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input int s, input logic [7:0] c);
    logic [31:0] v;
    v = '0;
    v[8*s +: 8] = c;
    return v;
  endfunction

  // ---------------- scoreboard / source model ----------------
  typedef struct {
    logic [7:0] ch;
    int         src;
    bit         ab;
  } exp_t;

  exp_t               sbq[$];
  string              cur[NUM_REQ];
  int                 pos[NUM_REQ];
  int                 more[NUM_REQ];
  int                 nmsg[NUM_REQ];
  logic [NUM_REQ-1:0] act;
  bit                 prev_end;

  task automatic load(input int s, input string m, input bit ab_last);
    exp_t e;
    cur[s] = m;
    pos[s] = 0;
    act[s] = 1'b1;
    for (int i = 0; i < m.len(); i++) begin
      e.ch  = m[i];
      e.src = s;
      e.ab  = ab_last && (i == m.len() - 1);
      sbq.push_back(e);
    end
  endtask

  function automatic string gen_msg(input int s, input int n);
    return $sformatf("^c%0d m%0d $ 1 <= %08h#", s, n, n * 17 + s);
  endfunction

  task automatic monitor();
    exp_t e;
    bit   exp_ab;
    exp_ab = 1'b0;
    if (prev_end) chk("idle gap after release", bus.out_valid, 0);
    prev_end = 1'b0;
    if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected char: got %0h expected no output", bus.out_char);
      end else begin
        e = sbq.pop_front();
        chk("out_char", bus.out_char, e.ch);
        chk("grant_id", bus.grant_id, 32'(e.src));
        exp_ab   = e.ab;
        prev_end = (e.ch == CH_END) || e.ab;
      end
    end
    chk("abort", bus.abort, exp_ab);
  endtask

  task automatic cycle();
    logic [NUM_REQ-1:0] hs;
    string t;
    for (int s = 0; s < NUM_REQ; s++) begin
      bus.req_valid[s] = act[s];
      if (act[s]) begin
        t = cur[s];
        bus.req_char[8*s +: 8] = t[pos[s]];
      end else begin
        bus.req_char[8*s +: 8] = 8'h00;
      end
    end
    #2;
    hs = bus.req_valid & bus.req_ready;
    tick();
    for (int s = 0; s < NUM_REQ; s++) begin
      if (hs[s]) begin
        pos[s]++;
        if (pos[s] == cur[s].len()) begin
          act[s] = 1'b0;
          if (more[s] > 0) begin
            more[s]--;
            nmsg[s]++;
            load(s, gen_msg(s, nmsg[s]), 1'b0);
          end
        end
      end
    end
    monitor();
  endtask

  task automatic run(input string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || act != '0) && n < 3000) begin
      cycle();
      n++;
    end
    if (sbq.size() != 0 || act != '0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got %0d chars pending expected 0", name, sbq.size());
    end
    cycle();
    cycle();
    chk({name, " busy at end"}, bus.busy, 0);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_char  = '0;
    act           = '0;
    more          = '{default: 0};
    nmsg          = '{default: 0};
    sbq.delete();
    prev_end      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [31:0] chars;
    logic [3:0]  ready;
    logic        ov;
    logic [7:0]  ch;
    logic [1:0]  grant;
    logic        busy;
    logic        ab;
  } vec_t;

  vec_t tv[10];

  initial begin
    string m;

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_char  = '0;

    // ---- reset state ----
    do_reset();
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_char", bus.out_char, 8'h00);
    chk("reset grant_id", bus.grant_id, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset abort", bus.abort, 0);
    chk("reset req_ready", bus.req_ready, 0);

    // ---- table: arbitration, ready timing, stall beat, rotation ----
    tv[0] = '{4'b0100, pk(2, "^"),              4'b0000, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0};
    tv[1] = '{4'b0100, pk(2, "^"),              4'b0100, 1'b1, "^",   2'd2, 1'b1, 1'b0};
    tv[2] = '{4'b0000, 32'h0,                   4'b0100, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0};
    tv[3] = '{4'b0100, pk(2, "a"),              4'b0100, 1'b1, "a",   2'd2, 1'b1, 1'b0};
    tv[4] = '{4'b0110, pk(2, "#") | pk(1, "x"), 4'b0100, 1'b1, "#",   2'd2, 1'b0, 1'b0};
    tv[5] = '{4'b0010, pk(1, "x"),              4'b0000, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0};
    tv[6] = '{4'b0010, pk(1, "#"),              4'b0010, 1'b1, "#",   2'd1, 1'b0, 1'b0};
    tv[7] = '{4'b0001, pk(0, "^"),              4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0};
    tv[8] = '{4'b0001, pk(0, "#"),              4'b0001, 1'b1, "#",   2'd0, 1'b0, 1'b0};
    tv[9] = '{4'b0000, 32'h0,                   4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    for (int r = 0; r < 10; r++) begin
      bus.req_valid = tv[r].valid;
      bus.req_char  = tv[r].chars;
      #2;
      chk($sformatf("tbl%0d req_ready", r), bus.req_ready, tv[r].ready);
      tick();
      chk($sformatf("tbl%0d out_valid", r), bus.out_valid, tv[r].ov);
      if (tv[r].ov) chk($sformatf("tbl%0d out_char", r), bus.out_char, tv[r].ch);
      chk($sformatf("tbl%0d grant_id", r), bus.grant_id, tv[r].grant);
      chk($sformatf("tbl%0d busy", r), bus.busy, tv[r].busy);
      chk($sformatf("tbl%0d abort", r), bus.abort, tv[r].ab);
    end

    // ---- single source message ----
    do_reset();
    load(0, "^10@00003000: $ 1 <= 0000000a#", 1'b0);
    run("single");

    // ---- simultaneous sources 1 and 2, rr_ptr=0: 1 first ----
    do_reset();
    load(1, "^from one $ 11#", 1'b0);
    load(2, "^from two ^ 22#", 1'b0);
    run("pair");

    // ---- over-length message, source 3 waiting ----
    do_reset();
    m = "";
    for (int i = 0; i < MAX_LEN; i++) m = $sformatf("%s%c", m, 8'h41 + (i % 26));
    load(0, m, 1'b1);
    load(3, "^3#", 1'b0);
    run("maxlen");

    // ---- alternating continuous sources ----
    do_reset();
    more[0] = 2;
    more[1] = 2;
    load(0, gen_msg(0, 0), 1'b0);
    load(1, gen_msg(1, 0), 1'b0);
    run("alternate");

    // ---- stalled owner ----
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_char  = pk(0, "^");
    tick();
    chk("stall arb busy", bus.busy, 1);
    tick();
    chk("stall ^ out", bus.out_char, "^");
    bus.req_char = pk(0, "a");
    tick();
    bus.req_char = pk(0, "b");
    tick();
    chk("stall b out", bus.out_char, "b");
    bus.req_valid = '0;
`ifdef TRACE_ARB_TIMEOUT_EN
    for (int k = 1; k <= STALL_MAX; k++) begin
      tick();
      chk($sformatf("stall%0d busy", k), bus.busy, (k < STALL_MAX) ? 1 : 0);
      chk($sformatf("stall%0d abort", k), bus.abort, (k == STALL_MAX) ? 1 : 0);
    end
    tick();
    chk("stall abort cleared", bus.abort, 0);
    bus.req_valid = 4'b0011;
    bus.req_char  = pk(0, "c") | pk(1, "^");
    tick();
    chk("stall rr_ptr=1 grant", bus.grant_id, 1);
`else
    for (int k = 1; k <= STALL_MAX + 8; k++) begin
      tick();
      chk($sformatf("stall%0d busy", k), bus.busy, 1);
      chk($sformatf("stall%0d abort", k), bus.abort, 0);
    end
    bus.req_valid = 4'b0001;
    bus.req_char  = pk(0, "c");
    tick();
    chk("resume valid", bus.out_valid, 1);
    chk("resume char", bus.out_char, "c");
    bus.req_char = pk(0, "#");
    tick();
    chk("resume end char", bus.out_char, "#");
    chk("resume released", bus.busy, 0);
    chk("resume abort", bus.abort, 0);
`endif

    // ---- reset during HOLD after 10 chars ----
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_char  = pk(2, "k");
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("pre-reset busy", bus.busy, 1);
    chk("pre-reset grant", bus.grant_id, 2);
    chk("pre-reset out_valid", bus.out_valid, 1);
    reset = 1'b1;
    tick();
    chk("midreset busy", bus.busy, 0);
    chk("midreset out_valid", bus.out_valid, 0);
    chk("midreset req_ready", bus.req_ready, 0);
    chk("midreset grant_id", bus.grant_id, 0);
    chk("midreset abort", bus.abort, 0);
    reset         = 1'b0;
    bus.req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/trace_stream_arbiter.md
Name: trace_stream_arbiter

Overview:
- Shares one cpu_checker character port between NUM_REQ trace sources, such as multiple CPU cores or testbench channels.
- Grants are message-granular. A source keeps the checker from grant until it delivers the '#' terminator, so characters from different sources never interleave inside a checker message.
- Arbitration is round-robin. Forced release on over-length messages and, optionally, on a stalled source.
- The forwarded stream is registered. The checker wrapper advances only when out_valid=1.

Parameters:
- NUM_REQ, 4, number of requesting trace sources.
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).
- MAX_LEN, 64, chars forwarded in one grant before forced release.
- STALL_MAX, 32, consecutive stall cycles before forced release (TIMEOUT_EN only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset; clock clk.
- req_valid  in  NUM_REQ  source i presents a char.
- req_char  in  8*NUM_REQ  char of source i in bits [8i+7:8i].
- req_ready  out  NUM_REQ  char of source i is consumed this cycle (valid&&ready).
- out_char  out  8  registered char to checker.
- out_valid  out  1  out_char is valid this cycle.
- grant_id  out  ID_W  index of the current owner.
- busy  out  1  a grant is held (state HOLD).
- abort  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, len_cnt=0, stall_cnt=0. All outputs are 0, including out_char=8'h00. Reset mid-message drops the grant immediately; the partial char is not forwarded.

States:
- IDLE:
  - req_ready is all 0.
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap. Register it into grant_id, clear len_cnt and stall_cnt, and go to HOLD next cycle.
  - The arbitration cycle consumes no character.
- HOLD:
  - req_ready[grant_id] = 1, all other bits 0. This output is combinational from state and grant_id.
  - On req_valid[grant_id]:
    - Next cycle out_char=char and out_valid=1; 1-cycle latency.
    - len_cnt increments and stall_cnt clears.
  - Otherwise out_valid=0 next cycle and stall_cnt increments.
  - Release conditions, evaluated on the transfer/stall in that cycle:
    - Normal: the transferred char == "#". The '#' itself is forwarded. Go to IDLE; no abort.
    - Length: the transfer makes len_cnt == MAX_LEN without a '#'. Go to IDLE and pulse abort next cycle.
    - Stall (TIMEOUT_EN): stall_cnt reaches STALL_MAX. Go to IDLE and pulse abort.
  - If '#' and MAX_LEN coincide, the release is normal (no abort).
  - On any release, rr_ptr = grant_id+1 mod NUM_REQ.
  - A '^' mid-grant is forwarded unchanged and does not release.
- out_valid is 0 in every cycle following an IDLE cycle. Back-to-back messages therefore have at least one idle beat between them.
- grant_id holds its last value in IDLE. busy = (state==HOLD).
- Simultaneous requests in IDLE: strict rotation. A source that just released has the lowest priority.
- With NUM_REQ=1 the block degenerates to a pass-through with the IDLE gap.

Optional Feature:
- Macro: TRACE_ARB_TIMEOUT_EN.
- Defined: the stall counter and stall release are present. The abort pulse also occurs on stall release.
- Undefined: there is no stall_cnt logic. A stalled owner holds the grant until '#' or MAX_LEN; abort is driven only by MAX_LEN.

Decomposition:
- Shared package trace_pkg:
  - Char constants CH_START="^", CH_END="#".
  - State enum {IDLE, HOLD}.
  - Default MAX_LEN and STALL_MAX.
- Sub-module rr_picker (combinational): inputs req vector and rr_ptr; outputs winner index and any_req. Reused by other round-robin blocks.

Test Plan:
- Single source 0 sends "^10@00003000: $ 1 <= 0000000a#" with no stalls. Response: grant_id=0; out_char reproduces the string 1 cycle delayed; abort=0; IDLE after '#'.
- Sources 1 and 2 request at the same time with rr_ptr=0. Response: source 1 is served fully through '#', then at least one gap cycle, then source 2. No interleaved chars appear on out_char.
- Source 0 streams 64 chars without '#'. Response: abort pulses one cycle after the 64th char; source 3, waiting, is granted next.
- With TRACE_ARB_TIMEOUT_EN, source 0 valid drops for 32 cycles mid-message. Response: abort and release, and rr_ptr=1. Without the macro: grant is held and forwarding resumes when valid returns.
- Assert reset during HOLD with 10 chars forwarded. Response next cycle: busy=0, out_valid=0, req_ready=0, grant_id=0.
- Two sources alternately emit continuous messages. Response: grants alternate 0,1,0,1, and each message is delivered intact.
